// File: rtl/instr_fetch_arbiter_pkg.sv
// Shared constants, core-id width helper and stage-1 fetch record for the fetch arbiter.
package instr_fetch_arbiter_pkg;

    localparam int ADDR_W         = 16;
    localparam int INSTR_W        = 16;
    localparam int CORE_ID_MAX_W  = 3;

    function automatic int core_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [ADDR_W-1:0]        addr;
        logic [CORE_ID_MAX_W-1:0] core_id;
    } fetch_req_t;

endpackage

// File: rtl/instr_fetch_arbiter_if.sv
// Core-side fetch handshake plus instruction-memory pins shared by the arbiter and its users.
interface instr_fetch_arbiter_if #(
    parameter int NUM_CORES = 4
);
    import instr_fetch_arbiter_pkg::*;

    logic                          enable;
    logic [NUM_CORES-1:0]          req;
    logic [NUM_CORES*ADDR_W-1:0]   req_addr;
    logic [NUM_CORES-1:0]          gnt;
    logic [NUM_CORES-1:0]          resp_valid;
    logic [INSTR_W-1:0]            resp_instr;
    logic                          mem_read;
    logic [ADDR_W-1:0]             mem_address;
    logic [INSTR_W-1:0]            mem_instr;

    modport slave (
        input  enable, req, req_addr, mem_instr,
        output gnt, resp_valid, resp_instr, mem_read, mem_address
    );

    modport master (
        output enable, req, req_addr, mem_instr,
        input  gnt, resp_valid, resp_instr, mem_read, mem_address
    );

endinterface

// File: rtl/instr_fetch_arbiter_picker.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, modulo NUM_CORES.
module rr_priority_picker
    import instr_fetch_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int IDW       = core_id_w(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] eligible,
    input  logic [IDW-1:0]       rr_ptr,
    output logic [NUM_CORES-1:0] winner_oh,
    output logic [IDW-1:0]       winner_idx,
    output logic                 any_valid
);

    logic [NUM_CORES-1:0] rotated;
    logic [IDW:0]         sum;

    always_comb begin
        any_valid = 1'b0;
        sum       = '0;
        rotated   = NUM_CORES'({eligible, eligible} >> rr_ptr);
        // Descending scan so the lowest rotated offset (closest to rr_ptr) wins.
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                any_valid = 1'b1;
                sum       = {1'b0, rr_ptr} + (IDW+1)'(j);
            end
        end
        winner_idx = (sum >= (IDW+1)'(NUM_CORES)) ? IDW'(sum - (IDW+1)'(NUM_CORES)) : IDW'(sum);
        winner_oh  = any_valid ? (NUM_CORES'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/instr_fetch_arbiter.sv
// Round-robin arbiter sharing one instruction memory among NUM_CORES cores; gnt -> resp_valid is 2 cycles.
// A granted core stays busy until its response, and enable=0 stops new grants while in-flight fetches drain.
module instr_fetch_arbiter
    import instr_fetch_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instr_fetch_arbiter_if.slave  bus
);

    localparam int IDW = core_id_w(NUM_CORES);

    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] winner_oh;
    logic [IDW-1:0]       winner_idx;
    logic                 any_valid;

    logic [NUM_CORES-1:0] busy_q, busy_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                 mem_read_q, mem_read_d;
    fetch_req_t           s1_q, s1_d;
    logic [NUM_CORES-1:0] resp_valid_q, resp_valid_d;
    logic [INSTR_W-1:0]   resp_instr_q, resp_instr_d;

    // Gating with reset_n keeps gnt low while reset is held.
    assign eligible = bus.req & ~busy_q & {NUM_CORES{bus.enable & reset_n}};

    rr_priority_picker #(
        .NUM_CORES (NUM_CORES),
        .IDW       (IDW)
    ) u_picker (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr_q),
        .winner_oh  (winner_oh),
        .winner_idx (winner_idx),
        .any_valid  (any_valid)
    );

    always_comb begin
        busy_d       = busy_q;
        rr_ptr_d     = rr_ptr_q;
        mem_read_d   = any_valid;
        s1_d         = s1_q;
        resp_valid_d = '0;
        resp_instr_d = resp_instr_q;

        if (mem_read_q) begin
            resp_instr_d           = bus.mem_instr;
            resp_valid_d           = NUM_CORES'(1) << s1_q.core_id;
            busy_d[s1_q.core_id]   = 1'b0;
        end

        if (any_valid) begin
            busy_d[winner_idx] = 1'b1;
            s1_d.addr          = bus.req_addr[winner_idx*ADDR_W +: ADDR_W];
            s1_d.core_id       = CORE_ID_MAX_W'(winner_idx);
            rr_ptr_d           = (winner_idx == IDW'(NUM_CORES - 1)) ? '0 : winner_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q       <= '0;
            rr_ptr_q     <= '0;
            mem_read_q   <= 1'b0;
            s1_q         <= '0;
            resp_valid_q <= '0;
            resp_instr_q <= '0;
        end else begin
            busy_q       <= busy_d;
            rr_ptr_q     <= rr_ptr_d;
            mem_read_q   <= mem_read_d;
            s1_q         <= s1_d;
            resp_valid_q <= resp_valid_d;
            resp_instr_q <= resp_instr_d;
        end
    end

    assign bus.gnt         = winner_oh;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = s1_q.addr;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_instr  = resp_instr_q;

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Bench for instr_fetch_arbiter: per-scenario tasks compared against a transaction-level reference model.
module tb_instr_fetch_arbiter;
    import instr_fetch_arbiter_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    instr_fetch_arbiter_if #(.NUM_CORES(N)) bus ();

    instr_fetch_arbiter #(.NUM_CORES(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Instruction memory contents as a fixed function of the address.
    function automatic logic [INSTR_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    assign bus.mem_instr = mem_fn(bus.mem_address);

    int checks = 0;
    int errors = 0;
    int cyc    = 2;

    // Reference model: a log of grants indexed by the cycle they happened in.
    bit                g_valid [0:4095];
    int                g_core  [0:4095];
    logic [ADDR_W-1:0] g_addr  [0:4095];
    int                rr = 0;
    logic [ADDR_W-1:0]  last_addr  = '0;
    logic [INSTR_W-1:0] last_instr = '0;
    bit                known      = 1'b0;
    bit                regs_known = 1'b0;

    logic [N-1:0]       exp_gnt, obs_gnt, exp_rv, obs_rv;
    logic               exp_rd, obs_rd;
    logic [ADDR_W-1:0]  exp_ma, obs_ma;
    logic [INSTR_W-1:0] exp_ri, obs_ri;
    string              obs_s, exp_s;

    task automatic step();
        int w;
        int i;
        @(negedge clk);
        obs_gnt = bus.gnt;
        obs_rd  = bus.mem_read;
        obs_ma  = bus.mem_address;
        obs_rv  = bus.resp_valid;
        obs_ri  = bus.resp_instr;

        w = -1;
        if (reset_n && bus.enable) begin
            for (int k = 0; k < N; k++) begin
                i = (rr + k) % N;
                // A core granted last cycle still has its fetch outstanding.
                if (w < 0 && bus.req[i] && !(g_valid[cyc-1] && g_core[cyc-1] == i))
                    w = i;
            end
        end
        exp_gnt = (w >= 0) ? (N'(1) << w) : '0;
        exp_rd  = g_valid[cyc-1];
        exp_ma  = g_valid[cyc-1] ? g_addr[cyc-1] : last_addr;
        exp_rv  = g_valid[cyc-2] ? (N'(1) << g_core[cyc-2]) : '0;
        exp_ri  = g_valid[cyc-2] ? mem_fn(g_addr[cyc-2]) : last_instr;

        obs_s = $sformatf("gnt=%b rd=%b ma=%h rv=%b ri=%h", obs_gnt, obs_rd, obs_ma, obs_rv, obs_ri);
        exp_s = $sformatf("gnt=%b rd=%b ma=%h rv=%b ri=%h", exp_gnt, exp_rd, exp_ma, exp_rv, exp_ri);
        regs_known = known;

        last_addr    = exp_ma;
        last_instr   = exp_ri;
        g_valid[cyc] = (w >= 0);
        if (w >= 0) begin
            g_core[cyc] = w;
            g_addr[cyc] = bus.req_addr[w*ADDR_W +: ADDR_W];
            rr          = (w + 1) % N;
        end
        if (!reset_n) begin
            g_valid[cyc]   = 1'b0;
            g_valid[cyc-1] = 1'b0;
            last_addr      = '0;
            last_instr     = '0;
            rr             = 0;
            known          = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.enable   = 1'b1;
        bus.req      = '1;
        bus.req_addr = {16'd3, 16'd2, 16'd1, 16'd0};
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (obs_gnt !== 4'b0000) begin
                errors++;
                $display("FAIL reset_gnt cyc=%0d actual=%b required=0000", cyc, obs_gnt);
            end
            if (regs_known) begin
                checks++;
                if ({obs_rd, obs_ma, obs_rv, obs_ri} !== 37'd0) begin
                    errors++;
                    $display("FAIL reset_regs cyc=%0d actual %s required all zero", cyc, obs_s);
                end
            end
        end
    endtask

    task automatic test_single_fetch();
        reset_n = 1'b1;
        bus.req = '0;
        for (int c = 0; c < 6; c++) begin
            bus.req      = (c == 2) ? 4'b0001 : 4'b0000;
            bus.req_addr = {16'd0, 16'd0, 16'd0, 16'd5};
            step();
            checks++;
            if (obs_s != exp_s) begin
                errors++;
                $display("FAIL single cyc=%0d actual %s required %s", cyc, obs_s, exp_s);
            end
            if (c == 2) begin
                checks++;
                if (obs_gnt !== 4'b0001) begin
                    errors++;
                    $display("FAIL single_gnt actual=%b required=0001", obs_gnt);
                end
            end
            if (c == 3) begin
                checks++;
                if (obs_rd !== 1'b1 || obs_ma !== 16'd5) begin
                    errors++;
                    $display("FAIL single_mem actual rd=%b ma=%h required rd=1 ma=0005", obs_rd, obs_ma);
                end
            end
            if (c == 4) begin
                checks++;
                if (obs_rv !== 4'b0001 || obs_ri !== mem_fn(16'd5)) begin
                    errors++;
                    $display("FAIL single_resp actual rv=%b ri=%h required rv=0001 ri=%h", obs_rv, obs_ri, mem_fn(16'd5));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        bus.req = '0;
        reset_n = 1'b0;
        step();
        step();
        reset_n      = 1'b1;
        bus.req      = '1;
        bus.req_addr = {16'd3, 16'd2, 16'd1, 16'd0};
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (obs_s != exp_s) begin
                errors++;
                $display("FAIL rr_model cyc=%0d actual %s required %s", cyc, obs_s, exp_s);
            end
            checks++;
            if (obs_gnt !== (N'(1) << (k % N))) begin
                errors++;
                $display("FAIL rr_order k=%0d actual=%b required=%b", k, obs_gnt, N'(1) << (k % N));
            end
        end
    endtask

    task automatic test_hold_after_gnt();
        int n_gnt;
        int n_resp;
        n_gnt  = 0;
        n_resp = 0;
        bus.req = '0;
        step();
        step();
        bus.req_addr = {16'd0, 16'h0022, 16'd0, 16'd0};
        for (int c = 0; c < 6; c++) begin
            bus.req = (c < 2) ? 4'b0100 : 4'b0000;
            step();
            checks++;
            if (obs_s != exp_s) begin
                errors++;
                $display("FAIL hold_model cyc=%0d actual %s required %s", cyc, obs_s, exp_s);
            end
            n_gnt  += int'(obs_gnt[2]);
            n_resp += int'(obs_rv[2]);
        end
        checks++;
        if (n_gnt != 1 || n_resp != 1) begin
            errors++;
            $display("FAIL hold_count actual gnt=%0d resp=%0d required gnt=1 resp=1", n_gnt, n_resp);
        end
    endtask

    task automatic test_enable_drain();
        bus.req      = 4'b0010;
        bus.req_addr = {16'h0043, 16'h0042, 16'h0011, 16'h0040};
        step();
        checks++;
        if (obs_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL en_first_gnt actual=%b required=0010", obs_gnt);
        end
        bus.enable = 1'b0;
        bus.req    = '1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (obs_s != exp_s || obs_gnt !== 4'b0000) begin
                errors++;
                $display("FAIL en_drain cyc=%0d actual %s required %s", cyc, obs_s, exp_s);
            end
            if (c == 1) begin
                checks++;
                if (obs_rv !== 4'b0010 || obs_ri !== mem_fn(16'h0011)) begin
                    errors++;
                    $display("FAIL en_resp actual rv=%b ri=%h required rv=0010 ri=%h", obs_rv, obs_ri, mem_fn(16'h0011));
                end
            end
        end
        bus.enable = 1'b1;
        step();
        checks++;
        if (obs_gnt !== 4'b0100) begin
            errors++;
            $display("FAIL en_resume_gnt actual=%b required=0100", obs_gnt);
        end
        bus.req = '0;
        for (int c = 0; c < 3; c++) step();
    endtask

    task automatic test_reset_mid();
        bus.req      = 4'b1000;
        bus.req_addr = {16'd35, 16'd0, 16'd0, 16'd0};
        step();
        checks++;
        if (obs_gnt !== 4'b1000) begin
            errors++;
            $display("FAIL mid_gnt actual=%b required=1000", obs_gnt);
        end
        bus.req = '0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (obs_rv !== 4'b0000 || obs_s != exp_s) begin
                errors++;
                $display("FAIL mid_dropped cyc=%0d actual %s required %s", cyc, obs_s, exp_s);
            end
        end
        bus.req = 4'b1000;
        step();
        checks++;
        if (obs_gnt !== 4'b1000) begin
            errors++;
            $display("FAIL mid_regrant actual=%b required=1000", obs_gnt);
        end
        bus.req = '0;
        step();
        step();
        checks++;
        if (obs_rv !== 4'b1000 || obs_ri !== mem_fn(16'd35)) begin
            errors++;
            $display("FAIL mid_resp actual rv=%b ri=%h required rv=1000 ri=%h", obs_rv, obs_ri, mem_fn(16'd35));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            reset_n      = ($urandom_range(0, 63) != 0);
            bus.enable   = ($urandom_range(0, 9) != 0);
            bus.req      = N'($urandom);
            bus.req_addr = {$urandom, $urandom};
            step();
            checks++;
            if (obs_s != exp_s) begin
                errors++;
                $display("FAIL random cyc=%0d actual %s required %s", cyc, obs_s, exp_s);
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.enable   = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_hold_after_gnt();
        test_enable_drain();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
